// File: rtl/fft_fp2int_unit_ctrl.sv
// Four-lane dispatcher for fp2int HLS cores. Results are returned in acceptance order.
// Optional build macro FP2INT_SAT_CHECK_EN resolves NaN and out-of-range words locally, without using a core.
module fft_fp2int_unit_ctrl (
  input  logic        s_axi_aclk,
  input  logic        s_axi_areset,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_fp_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_int_data,
  output logic        ap_start_0,
  output logic        ap_start_1,
  output logic        ap_start_2,
  output logic        ap_start_3,
  input  logic        ap_done_0,
  input  logic        ap_done_1,
  input  logic        ap_done_2,
  input  logic        ap_done_3,
  output logic [31:0] input_r_0,
  output logic [31:0] input_r_1,
  output logic [31:0] input_r_2,
  output logic [31:0] input_r_3,
  input  logic [31:0] output_r_0,
  input  logic [31:0] output_r_1,
  input  logic [31:0] output_r_2,
  input  logic [31:0] output_r_3,
  output logic        sat_flag
);

  localparam logic [1:0] LANE_IDLE = 2'd0;
  localparam logic [1:0] LANE_RUN  = 2'd1;
  localparam logic [1:0] LANE_HOLD = 2'd2;

  logic [1:0]  lane_q   [4];
  logic [1:0]  lane_d   [4];
  logic [31:0] result_q [4];
  logic [31:0] result_d [4];
  logic [31:0] input_q  [4];
  logic [31:0] input_d  [4];
  logic [31:0] out_s    [4];
  logic [3:0]  done_s;
  logic [3:0]  ap_start_q, ap_start_d;
  logic [1:0]  issue_q, issue_d, collect_q, collect_d;
  logic        s_ready_q, s_ready_d, m_valid_q, m_valid_d;
  logic [31:0] m_data_q, m_data_d;
  logic        accept_s, release_s;

`ifdef FP2INT_SAT_CHECK_EN
  logic        sat_q, sat_d;
  logic [32:0] cls_s;

  // {flag, value}: flag set when the word is resolved without a core
  function automatic logic [32:0] sat_classify(input logic [31:0] w);
    logic [32:0] r;
    if (w[30:23] == 8'hFF && w[22:0] != 23'h0) begin
      r = {1'b1, 32'h0000_0000};
    end else if (w[30:23] >= 8'd158) begin
      r = w[31] ? {1'b1, 32'h8000_0000} : {1'b1, 32'h7FFF_FFFF};
    end else begin
      r = {1'b0, 32'h0000_0000};
    end
    return r;
  endfunction

  assign cls_s    = sat_classify(s_fp_data);
  assign sat_flag = sat_q;
`else
  assign sat_flag = 1'b0;
`endif

  assign done_s   = {ap_done_3, ap_done_2, ap_done_1, ap_done_0};
  assign out_s[0] = output_r_0;
  assign out_s[1] = output_r_1;
  assign out_s[2] = output_r_2;
  assign out_s[3] = output_r_3;

  assign accept_s  = s_valid && s_ready_q;
  assign release_s = m_valid_q && m_ready;

  always_comb begin
    lane_d    = lane_q;
    result_d  = result_q;
    input_d   = input_q;
    issue_d   = issue_q;
    collect_d = collect_q;
`ifdef FP2INT_SAT_CHECK_EN
    sat_d     = sat_q;
`endif
    for (int k = 0; k < 4; k++) begin
      if (lane_q[k] == LANE_RUN && done_s[k]) begin
        lane_d[k]   = LANE_HOLD;
        result_d[k] = out_s[k];
      end else begin
        lane_d[k]   = lane_d[k];
      end
    end
    // Released and issued lanes never coincide: one is HOLD, the other IDLE
    if (release_s) begin
      lane_d[collect_q] = LANE_IDLE;
      collect_d         = collect_q + 2'd1;
    end else begin
      collect_d         = collect_q;
    end
    if (accept_s) begin
      input_d[issue_q] = s_fp_data;
      lane_d[issue_q]  = LANE_RUN;
      issue_d          = issue_q + 2'd1;
`ifdef FP2INT_SAT_CHECK_EN
      if (cls_s[32]) begin
        lane_d[issue_q]   = LANE_HOLD;
        result_d[issue_q] = cls_s[31:0];
        sat_d             = 1'b1;
      end else begin
        sat_d             = sat_d;
      end
`endif
    end else begin
      issue_d = issue_q;
    end
    for (int k = 0; k < 4; k++) begin
      ap_start_d[k] = (lane_d[k] == LANE_RUN);
    end
    // Handshake outputs are registered images of the next lane state
    s_ready_d = (lane_d[issue_d] == LANE_IDLE);
    m_valid_d = (lane_d[collect_d] == LANE_HOLD);
    m_data_d  = result_d[collect_d];
  end

  always_ff @(posedge s_axi_aclk) begin
    if (s_axi_areset) begin
      for (int k = 0; k < 4; k++) begin
        lane_q[k]   <= LANE_IDLE;
        result_q[k] <= 32'h0000_0000;
        input_q[k]  <= 32'h0000_0000;
      end
      issue_q    <= 2'd0;
      collect_q  <= 2'd0;
      ap_start_q <= 4'b0000;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
      m_data_q   <= 32'h0000_0000;
`ifdef FP2INT_SAT_CHECK_EN
      sat_q      <= 1'b0;
`endif
    end else begin
      lane_q     <= lane_d;
      result_q   <= result_d;
      input_q    <= input_d;
      issue_q    <= issue_d;
      collect_q  <= collect_d;
      ap_start_q <= ap_start_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
`ifdef FP2INT_SAT_CHECK_EN
      sat_q      <= sat_d;
`endif
    end
  end

  assign s_ready    = s_ready_q;
  assign m_valid    = m_valid_q;
  assign m_int_data = m_data_q;
  assign ap_start_0 = ap_start_q[0];
  assign ap_start_1 = ap_start_q[1];
  assign ap_start_2 = ap_start_q[2];
  assign ap_start_3 = ap_start_q[3];
  assign input_r_0  = input_q[0];
  assign input_r_1  = input_q[1];
  assign input_r_2  = input_q[2];
  assign input_r_3  = input_q[3];

endmodule

// File: tb/tb_fft_fp2int_unit_ctrl.sv
// Self-checking bench for fft_fp2int_unit_ctrl: it models four fp2int cores and scoreboards results in acceptance order.
module tb_fft_fp2int_unit_ctrl;

  logic        clk = 1'b0;
  logic        s_axi_areset, s_valid, s_ready, m_valid, m_ready, sat_flag;
  logic [31:0] s_fp_data, m_int_data;
  logic        ap_start_0, ap_start_1, ap_start_2, ap_start_3;
  logic        ap_done_0, ap_done_1, ap_done_2, ap_done_3;
  logic [31:0] input_r_0, input_r_1, input_r_2, input_r_3;
  logic [31:0] output_r_0, output_r_1, output_r_2, output_r_3;

  logic [3:0]  start_v, busy, man_done;
  int          cnt [4];
  int          lat [4];
  int          cyc = 0;
  int          n_cmp = 0, n_err = 0, n_acc = 0, n_pop = 0;
  logic [31:0] sb_q [$];
  logic [31:0] cur_exp;
  logic        saw_start;
  logic [31:0] w6 [6] = '{32'h3F80_0000, 32'h4000_0000, 32'h4040_0000,
                          32'h4080_0000, 32'h40A0_0000, 32'h40C0_0000};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft_fp2int_unit_ctrl dut (
    .s_axi_aclk(clk), .s_axi_areset(s_axi_areset),
    .s_valid(s_valid), .s_ready(s_ready), .s_fp_data(s_fp_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_int_data(m_int_data),
    .ap_start_0(ap_start_0), .ap_start_1(ap_start_1), .ap_start_2(ap_start_2), .ap_start_3(ap_start_3),
    .ap_done_0(ap_done_0), .ap_done_1(ap_done_1), .ap_done_2(ap_done_2), .ap_done_3(ap_done_3),
    .input_r_0(input_r_0), .input_r_1(input_r_1), .input_r_2(input_r_2), .input_r_3(input_r_3),
    .output_r_0(output_r_0), .output_r_1(output_r_1), .output_r_2(output_r_2), .output_r_3(output_r_3),
    .sat_flag(sat_flag)
  );

  // Truncating float-to-int, as an fp2int core would compute it for in-range words
  function automatic logic [31:0] fp2int(input logic [31:0] w);
    logic [7:0]  e;
    logic [31:0] m, mag;
    e = w[30:23];
    m = {8'd0, 1'b1, w[22:0]};
    if (e < 8'd127)       mag = 32'd0;
    else if (e >= 8'd150) mag = m << (e - 8'd150);
    else                  mag = m >> (8'd150 - e);
    return w[31] ? (32'd0 - mag) : mag;
  endfunction

  assign start_v    = {ap_start_3, ap_start_2, ap_start_1, ap_start_0};
  assign ap_done_0  = (busy[0] && cnt[0] == lat[0]) | man_done[0];
  assign ap_done_1  = (busy[1] && cnt[1] == lat[1]) | man_done[1];
  assign ap_done_2  = (busy[2] && cnt[2] == lat[2]) | man_done[2];
  assign ap_done_3  = (busy[3] && cnt[3] == lat[3]) | man_done[3];
  assign output_r_0 = fp2int(input_r_0);
  assign output_r_1 = fp2int(input_r_1);
  assign output_r_2 = fp2int(input_r_2);
  assign output_r_3 = fp2int(input_r_3);

  // Core model: done pulses lat cycles after ap_start is first seen
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (s_axi_areset) begin
        busy[k] <= 1'b0;
      end else if (!busy[k] && start_v[k]) begin
        busy[k] <= 1'b1;
        cnt[k]  <= 1;
      end else if (busy[k]) begin
        if (cnt[k] == lat[k]) busy[k] <= 1'b0;
        else cnt[k] <= cnt[k] + 1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: sample mid-cycle (push on accept, pop/compare on delivery), then move past the edge
  task automatic step();
    logic [31:0] e;
    @(negedge clk);
    if (start_v != 4'b0000) saw_start = 1'b1;
    if (s_valid && s_ready) begin
      sb_q.push_back(cur_exp);
      n_acc++;
    end
    if (m_valid && m_ready) begin
      n_cmp++;
      assert (sb_q.size() > 0) else begin
        n_err++;
        $error("FAIL sb_empty: observed %h expected no output", m_int_data);
      end
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        n_pop++;
        assert (m_int_data === e) else begin
          n_err++;
          $error("FAIL sb_data: observed %h expected %h", m_int_data, e);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] w, input logic [31:0] e, output int acc_edge);
    int n0;
    n0 = n_acc;
    s_valid = 1'b1;
    s_fp_data = w;
    cur_exp = e;
    for (int t = 0; t < 50 && n_acc == n0; t++) step();
    acc_edge = cyc;
    s_valid = 1'b0;
    chk("send_accept", n_acc, n0 + 1);
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && sb_q.size() != 0; t++) step();
    chk("drain", sb_q.size(), 0);
  endtask

  initial begin
    int e0, ex, i, base;
    s_axi_areset = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_fp_data = 32'd0;
    man_done = 4'b0000; cur_exp = 32'd0; saw_start = 1'b0;
    for (int k = 0; k < 4; k++) lat[k] = 3;
    step(); step();
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_ap_start", start_v, 4'b0000);
    chk("rst_m_int_data", m_int_data, 0);
    chk("rst_sat_flag", sat_flag, 0);
    chk("rst_input_r_0", input_r_0, 0);
    s_axi_areset = 1'b0;
    chk("rst_next_s_ready", s_ready, 0);
    step();
    chk("post_rst_s_ready", s_ready, 1);

    // Back-to-back, latency 3 cores
    m_ready = 1'b1;
    send(32'h3F80_0000, 32'd1, e0);
    chk("ap_start_t1", ap_start_0, 1);
    send(32'hC040_0000, 32'hFFFF_FFFD, ex);
    send(32'h42F6_0000, 32'd123, ex);
    send(32'h0000_0000, 32'd0, ex);
    for (int t = 0; t < 20 && !m_valid; t++) step();
    chk("first_mvalid_cycle", cyc, e0 + 4);
    drain();
    chk("b2b_count", n_pop, 4);

    // Lane1 finishes 5 cycles before lane0
    lat[0] = 9; lat[1] = 3;
    send(32'h40A0_0000, 32'd5, ex);
    send(32'h4120_0000, 32'd10, ex);
    drain();
    chk("ooo_count", n_pop, 6);
    lat[0] = 3; lat[1] = 3;

    // Backpressure: 6 words offered with m_ready low
    m_ready = 1'b0;
    base = n_acc;
    i = 0;
    for (int t = 0; t < 30 && i < 6; t++) begin
      s_valid = 1'b1; s_fp_data = w6[i]; cur_exp = 32'(i + 1);
      step();
      if (n_acc > base + i) i++;
    end
    chk("bp_accepted", n_acc - base, 4);
    chk("bp_s_ready", s_ready, 0);
    chk("bp_m_valid", m_valid, 1);
    chk("bp_m_int_data", m_int_data, 32'd1);
    s_valid = 1'b0;
    step(); step(); step();
    chk("bp_hold_m_valid", m_valid, 1);
    chk("bp_hold_m_int_data", m_int_data, 32'd1);
    m_ready = 1'b1;
    for (int t = 0; t < 40 && i < 6; t++) begin
      s_valid = 1'b1; s_fp_data = w6[i]; cur_exp = 32'(i + 1);
      step();
      if (n_acc > base + i) i++;
    end
    s_valid = 1'b0;
    drain();
    chk("bp_delivered", n_pop, 12);
    step();
    chk("bp_no_dup", m_valid, 0);

    // Reset with two lanes running, then late ap_done pulses
    for (int k = 0; k < 4; k++) lat[k] = 30;
    send(32'h4040_0000, 32'd3, ex);
    send(32'h4080_0000, 32'd4, ex);
    step();
    chk("mid_run_starts", start_v, 4'b0011);
    s_axi_areset = 1'b1;
    step(); step();
    s_axi_areset = 1'b0;
    sb_q.delete();
    step();
    man_done = 4'b1111;
    step();
    man_done = 4'b0000;
    for (int t = 0; t < 4; t++) begin
      chk("late_done_m_valid", m_valid, 0);
      step();
    end
    chk("late_done_s_ready", s_ready, 1);
    for (int k = 0; k < 4; k++) lat[k] = 3;
    send(32'h40E0_0000, 32'd7, ex);
    chk("reissue_lane0", start_v, 4'b0001);
    drain();
    chk("reissue_count", n_pop, 13);

`ifdef FP2INT_SAT_CHECK_EN
    saw_start = 1'b0;
    send(32'h4F00_0000, 32'h7FFF_FFFF, ex);
    send(32'hFF80_0000, 32'h8000_0000, ex);
    send(32'h7FC0_0000, 32'h0000_0000, ex);
    drain();
    chk("sat_no_start", saw_start, 0);
    chk("sat_flag_set", sat_flag, 1);
`else
    chk("sat_flag_tied", sat_flag, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
